// File: rtl/sr_latch_bank_pkg.sv
// Shared policy encodings and next-state rule for the set/reset storage bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sr_pkg;

    localparam int POL_HOLD   = 0;
    localparam int POL_SET    = 1;
    localparam int POL_RST    = 2;
    localparam int POL_TOGGLE = 3;

    // Next stored bit from the current bit and the two qualified requests.
    // 'armed' is only consulted by the toggle policy: it is low while a
    // conflict interval that has already flipped q is still in progress.
    function automatic logic sr_next(
        input logic q,
        input logic qs,
        input logic qr,
        input int   policy,
        input logic armed
    );
        logic nxt;
        nxt = q;
        if (qs && !qr) begin
            nxt = 1'b1;
        end else if (!qs && qr) begin
            nxt = 1'b0;
        end else if (qs && qr) begin
            case (policy)
                POL_SET:    nxt = 1'b1;
                POL_RST:    nxt = 1'b0;
                POL_TOGGLE: nxt = armed ? ~q : q;
                default:    nxt = q;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sr_latch_bank_chan.sv
// One storage channel: glitch-filtered set/reset requests driving a registered q/qn pair.
// Latency: a request held FILTER+1 consecutive samples updates q on the FILTER+1'th rising edge.
// Backpressure: none; inputs are sampled every cycle and never stall.
module sr_chan
    import sr_pkg::*;
#(
    parameter int   POLICY  = POL_HOLD,
    parameter int   FILTER  = 2,
    parameter logic RESET_Q = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic se,
    input  logic re,
    output logic q,
    output logic qn,
    output logic conflict,
    output logic both_qual
);

    // A zero-length filter still needs a 1-bit counter; it simply never leaves 0.
    localparam int            CW      = (FILTER > 0) ? $clog2(FILTER + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER);

    logic [CW-1:0] cnt_s;
    logic [CW-1:0] cnt_r;
    logic          qs;
    logic          qr;
    logic          armed;
    logic          q_nxt;

    // A request qualifies once it has already been seen on FILTER earlier edges.
    assign qs        = se && (cnt_s == CNT_MAX);
    assign qr        = re && (cnt_r == CNT_MAX);
    assign both_qual = qs && qr;

    // Set-request run length, saturating at FILTER, cleared by any idle sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_s <= '0;
        end else if (!se) begin
            cnt_s <= '0;
        end else if (cnt_s != CNT_MAX) begin
            cnt_s <= cnt_s + 1'b1;
        end
    end

    // Reset-request run length, same rule as the set side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (!re) begin
            cnt_r <= '0;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    // Next stored bit, resolved through the shared policy rule.
    always_comb begin
        q_nxt = sr_next(q, qs, qr, POLICY, armed);
    end

    // q and qn come from the same next value so they can never be skewed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= RESET_Q;
            qn <= ~RESET_Q;
        end else begin
            q  <= q_nxt;
            qn <= ~q_nxt;
        end
    end

    // Toggle disarms while both requests stay qualified, re-arms as soon as either drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed    <= 1'b1;
            conflict <= 1'b0;
        end else begin
            armed    <= ~both_qual;
            conflict <= both_qual;
        end
    end

endmodule

// File: rtl/sr_latch_bank.sv
// N independent filtered set/reset storage channels with conflict pulses and a sticky error flag.
// Latency: a request held FILTER+1 samples acts on that edge; conflict/err_sticky register on the same edge.
// Backpressure: none; every channel samples its inputs each cycle.
module sr_latch_bank
    import sr_pkg::*;
#(
    parameter int           N          = 4,
    parameter int           ACTIVE_LOW = 1,
    parameter int           POLICY     = POL_HOLD,
    parameter int           FILTER     = 2,
    parameter logic [N-1:0] RESET_Q    = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] s,
    input  logic [N-1:0] r,
    input  logic         err_clr,
    output logic [N-1:0] q,
    output logic [N-1:0] qn,
    output logic [N-1:0] conflict,
    output logic         err_sticky
);

    localparam logic [N-1:0] POL_MASK = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    logic [N-1:0] se;
    logic [N-1:0] re;
    logic [N-1:0] both_qual;

    // Channels work on active-high requests regardless of pin polarity.
    assign se = s ^ POL_MASK;
    assign re = r ^ POL_MASK;

    for (genvar i = 0; i < N; i++) begin : g_chan
        sr_chan #(
            .POLICY  (POLICY),
            .FILTER  (FILTER),
            .RESET_Q (RESET_Q[i])
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .se        (se[i]),
            .re        (re[i]),
            .q         (q[i]),
            .qn        (qn[i]),
            .conflict  (conflict[i]),
            .both_qual (both_qual[i])
        );
    end

    // Sticky error: a conflict on this edge wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else begin
            err_sticky <= (err_sticky & ~err_clr) | (|both_qual);
        end
    end

endmodule

// File: tb/tb_sr_latch_bank.sv
// Bench for sr_latch_bank: four instances (one per conflict policy) share stimulus.
// Latency: vectors applied after a rising edge, outputs checked 1 time unit after the next one.
// Backpressure: n/a.
module tb_sr_latch_bank;

    logic       clk;
    logic       rst;
    logic [3:0] s;
    logic [3:0] r;
    logic       err_clr;

    logic [3:0] q_i  [4];
    logic [3:0] qn_i [4];
    logic [3:0] cf_i [4];
    logic       err_i[4];

    int errors = 0;
    int checks = 0;

    // Index g of eq is the expected q for the instance with POLICY=g.
    typedef struct {
        logic [3:0]      s;
        logic [3:0]      r;
        logic            clr;
        logic [3:0][3:0] eq;
        logic [3:0]      cf;
        logic            err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   split_idx;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sr_latch_bank #(
            .N          (4),
            .ACTIVE_LOW (1),
            .POLICY     (g),
            .FILTER     (2),
            .RESET_Q    (4'b1010)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .s          (s),
            .r          (r),
            .err_clr    (err_clr),
            .q          (q_i[g]),
            .qn         (qn_i[g]),
            .conflict   (cf_i[g]),
            .err_sticky (err_i[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Expected q per policy given as hold, set-dominant, reset-dominant, toggle.
    task automatic add(input logic [3:0] sv, input logic [3:0] rv, input logic clr,
                       input logic [3:0] qh, input logic [3:0] qsd, input logic [3:0] qrd,
                       input logic [3:0] qt, input logic [3:0] cf, input logic err);
        vec_t v;
        v.s   = sv;
        v.r   = rv;
        v.clr = clr;
        v.eq  = {qt, qrd, qsd, qh};
        v.cf  = cf;
        v.err = err;
        tbl.push_back(v);
    endtask

    task automatic check_reset_state(input string tag);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("%s q[%0d]", tag, g), q_i[g], 4'b1010);
            chk($sformatf("%s qn[%0d]", tag, g), qn_i[g], 4'b0101);
            chk($sformatf("%s conflict[%0d]", tag, g), cf_i[g], 4'b0000);
            chk($sformatf("%s err[%0d]", tag, g), {3'b000, err_i[g]}, 4'b0000);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        vec_t e;
        s       = v.s;
        r       = v.r;
        err_clr = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard v%0d: queue empty, required 1 entry", idx);
        end else begin
            e = sb.pop_front();
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("v%0d q pol%0d", idx, g), q_i[g], e.eq[g]);
                chk($sformatf("v%0d qn pol%0d", idx, g), qn_i[g], ~e.eq[g]);
                chk($sformatf("v%0d conflict pol%0d", idx, g), cf_i[g], e.cf);
            end
            chk($sformatf("v%0d err_sticky", idx), {3'b000, err_i[0]}, {3'b000, e.err});
        end
    endtask

    initial begin
        rst     = 1'b1;
        s       = 4'hF;
        r       = 4'hF;
        err_clr = 1'b0;

        // Filter: two active samples ignored, three act on the third edge.
        add(4'hE, 4'hF, 0, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'h0, 0);
        add(4'hE, 4'hF, 0, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'h0, 0);
        add(4'hF, 4'hF, 0, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'h0, 0);
        add(4'hE, 4'hF, 0, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'h0, 0);
        add(4'hE, 4'hF, 0, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'h0, 0);
        add(4'hE, 4'hF, 0, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'h0, 0);
        add(4'hF, 4'hF, 0, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'h0, 0);
        // Reset request on channel 1, then ten idle cycles of hold.
        add(4'hF, 4'hD, 0, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'h0, 0);
        add(4'hF, 4'hD, 0, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'h0, 0);
        add(4'hF, 4'hD, 0, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'h0, 0);
        for (int i = 0; i < 10; i++)
            add(4'hF, 4'hF, 0, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'h0, 0);
        // Five-cycle conflict on channel 2: qualified on the last three edges.
        add(4'hB, 4'hB, 0, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'h0, 0);
        add(4'hB, 4'hB, 0, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'h0, 0);
        for (int i = 0; i < 3; i++)
            add(4'hB, 4'hB, 0, 4'b1001, 4'b1101, 4'b1001, 4'b1101, 4'h4, 1);
        add(4'hF, 4'hF, 0, 4'b1001, 4'b1101, 4'b1001, 4'b1101, 4'h0, 1);
        // Clear with no conflict.
        add(4'hF, 4'hF, 1, 4'b1001, 4'b1101, 4'b1001, 4'b1101, 4'h0, 0);
        add(4'hF, 4'hF, 0, 4'b1001, 4'b1101, 4'b1001, 4'b1101, 4'h0, 0);
        // Clear held through a new conflict: conflict wins; toggle re-armed and flips back.
        add(4'hB, 4'hB, 1, 4'b1001, 4'b1101, 4'b1001, 4'b1101, 4'h0, 0);
        add(4'hB, 4'hB, 1, 4'b1001, 4'b1101, 4'b1001, 4'b1101, 4'h0, 0);
        add(4'hB, 4'hB, 1, 4'b1001, 4'b1101, 4'b1001, 4'b1001, 4'h4, 1);
        add(4'hF, 4'hF, 0, 4'b1001, 4'b1101, 4'b1001, 4'b1001, 4'h0, 1);
        add(4'hF, 4'hF, 1, 4'b1001, 4'b1101, 4'b1001, 4'b1001, 4'h0, 0);
        // One sample of a channel-3 reset request, then reset lands mid-filter.
        add(4'hF, 4'h7, 0, 4'b1001, 4'b1101, 4'b1001, 4'b1001, 4'h0, 0);
        split_idx = tbl.size();
        // After release the held request needs three fresh edges.
        add(4'hF, 4'h7, 0, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'h0, 0);
        add(4'hF, 4'h7, 0, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'h0, 0);
        add(4'hF, 4'h7, 0, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'h0, 0);
        add(4'hF, 4'hF, 0, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'h0, 0);

        // Reset held while inputs thrash.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s = 4'($urandom);
            r = 4'($urandom);
        end
        @(posedge clk);
        #1;
        check_reset_state("reset");
        s   = 4'hF;
        r   = 4'hF;
        rst = 1'b0;

        for (int i = 0; i < split_idx; i++)
            run_vec(i, tbl[i]);

        // Asynchronous reset between edges, with the channel-3 request still held.
        rst = 1'b1;
        #2;
        check_reset_state("async reset");
        #2;
        rst = 1'b0;

        for (int i = split_idx; i < tbl.size(); i++)
            run_vec(i, tbl[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
